// File: rtl/mem_pkg.sv
// Shared encodings for the load/store front end: access sizes, FSM states, default geometry.
package mem_pkg;
    localparam int DEPTH_LOG2_DEF = 5;
    localparam int DATA_W_DEF     = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts/extends load data and merges sub-word store data into the old word.
// Purely combinational; shared by the load-response and read-modify-write paths.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);
    logic [31:0] byte_shifted;
    logic [15:0] half_src;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;

    always_comb begin
        byte_sh      = {lane, 3'b000};
        half_sh      = {lane[1], 4'b0000};
        byte_shifted = old_word >> byte_sh;
        half_src     = lane[1] ? old_word[31:16] : old_word[15:0];
        byte_mask    = 32'h0000_00FF << byte_sh;
        half_mask    = 32'h0000_FFFF << half_sh;
        ld_data      = old_word;
        st_word      = wdata;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{~is_unsigned & byte_shifted[7]}}, byte_shifted[7:0]};
                st_word = (old_word & ~byte_mask) | ({24'b0, wdata[7:0]} << byte_sh);
            end
            SZ_HALF: begin
                ld_data = {{16{~is_unsigned & half_src[15]}}, half_src};
                st_word = (old_word & ~half_mask) | ({16'b0, wdata[15:0]} << half_sh);
            end
            default: begin
                ld_data = old_word;
                st_word = wdata;
            end
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-addressed memory: checks, RMW for sub-word stores, load extension.
// Latency accept->response: error 1, load 2, word store 2, sub-word store 3; REQ_READY only in IDLE.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic [1:0]        REQ_SIZE,
    input  logic              REQ_UNSIGNED,
    input  logic [DATA_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERROR,
    output logic              MEM_WRITE,
    output logic [DATA_W-1:0] MEM_ADRESS,
    output logic [DATA_W-1:0] MEM_WRITE_DATA,
    input  logic [DATA_W-1:0] MEM_READ_DATA
);
    state_t            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic              write_q, write_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] mem_adress_q, mem_adress_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;

    logic              req_err;
    logic              accept;
    logic [31:0]       ld_data;
    logic [31:0]       st_word;

    assign REQ_READY = (state_q == IDLE) && !RST;
    assign accept    = REQ_VALID && REQ_READY;

    assign req_err = (REQ_SIZE == SZ_ILL)
                   | ((REQ_SIZE == SZ_HALF) & REQ_ADDR[0])
                   | ((REQ_SIZE == SZ_WORD) & (|REQ_ADDR[1:0]))
                   | (|REQ_ADDR[DATA_W-1:DEPTH_LOG2+2]);

    // Fed straight from MEM's combinational read data during READ.
    mem_lane_align u_align (
        .old_word    (MEM_READ_DATA),
        .wdata       (wdata_q),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        size_d       = size_q;
        write_d      = write_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        mem_write_d  = 1'b0;
        mem_adress_d = mem_adress_q;
        mem_wdata_d  = mem_wdata_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = '0;
        rsp_error_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    lane_d  = REQ_ADDR[1:0];
                    size_d  = REQ_SIZE;
                    write_d = REQ_WRITE;
                    uns_d   = REQ_UNSIGNED;
                    wdata_d = REQ_WDATA;
                    if (req_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end else begin
                        mem_adress_d                   = '0;
                        mem_adress_d[DEPTH_LOG2-1:0]   = REQ_ADDR[DEPTH_LOG2+1:2];
                        if (REQ_WRITE && (REQ_SIZE == SZ_WORD)) begin
                            state_d     = WRITE;
                            mem_write_d = 1'b1;
                            mem_wdata_d = REQ_WDATA;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                if (write_q) begin
                    state_d     = WRITE;
                    mem_write_d = 1'b1;
                    mem_wdata_d = st_word;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ld_data;
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Async reset aborts any in-flight access; MEM_WRITE drops without waiting for a clock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            size_q       <= '0;
            write_q      <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            mem_write_q  <= 1'b0;
            mem_adress_q <= '0;
            mem_wdata_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            write_q      <= write_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            mem_write_q  <= mem_write_d;
            mem_adress_q <= mem_adress_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    assign MEM_WRITE      = mem_write_q;
    assign MEM_ADRESS     = mem_adress_q;
    assign MEM_WRITE_DATA = mem_wdata_q;
    assign RSP_VALID      = rsp_valid_q;
    assign RSP_RDATA      = rsp_rdata_q;
    assign RSP_ERROR      = rsp_error_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized traffic against a byte-level memory model.
module tb_mem_access_unit;
    localparam logic [1:0] S_B = 2'b00;
    localparam logic [1:0] S_H = 2'b01;
    localparam logic [1:0] S_W = 2'b10;
    localparam logic [1:0] S_X = 2'b11;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WRITE = 1'b0;
    logic [1:0]  REQ_SIZE = 2'b00;
    logic        REQ_UNSIGNED = 1'b0;
    logic [31:0] REQ_ADDR = '0;
    logic [31:0] REQ_WDATA = '0;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERROR;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADRESS;
    logic [31:0] MEM_WRITE_DATA;
    logic [31:0] MEM_READ_DATA;

    logic [31:0] mem     [0:31];
    bit   [31:0] ref_mem [0:31];

    int          checks = 0;
    int          errors = 0;
    bit   [31:0] last_rd;

    always #5 CLK = ~CLK;

    mem_access_unit dut (
        .CLK            (CLK),
        .RST            (RST),
        .REQ_VALID      (REQ_VALID),
        .REQ_READY      (REQ_READY),
        .REQ_WRITE      (REQ_WRITE),
        .REQ_SIZE       (REQ_SIZE),
        .REQ_UNSIGNED   (REQ_UNSIGNED),
        .REQ_ADDR       (REQ_ADDR),
        .REQ_WDATA      (REQ_WDATA),
        .RSP_VALID      (RSP_VALID),
        .RSP_RDATA      (RSP_RDATA),
        .RSP_ERROR      (RSP_ERROR),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_ADRESS     (MEM_ADRESS),
        .MEM_WRITE_DATA (MEM_WRITE_DATA),
        .MEM_READ_DATA  (MEM_READ_DATA)
    );

    // The memory itself: combinational read, write on the clock edge while MEM_WRITE is high.
    assign MEM_READ_DATA = mem[MEM_ADRESS[4:0]];
    always @(posedge CLK) if (MEM_WRITE) mem[MEM_ADRESS[4:0]] = MEM_WRITE_DATA;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: byte-granular memory, arithmetic extension, latency from access class.
    function automatic void model(input bit w, input bit [1:0] sz, input bit u, input bit [31:0] a,
                                  input bit [31:0] wd, output bit e, output bit [31:0] rd,
                                  output int lat, output bit [31:0] ww, output int nwr);
        int          idx, lane, nbytes;
        bit   [63:0] v, modv;
        bit   [7:0]  b [4];
        e   = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || (a >= 128);
        rd  = 0;
        ww  = 0;
        nwr = 0;
        lat = 1;
        if (!e) begin
            idx    = int'(a / 4);
            lane   = int'(a % 4);
            nbytes = 1 << sz;
            if (!w) begin
                modv = 64'd1 << (8 * nbytes);
                v    = ({32'd0, ref_mem[idx]} >> (8 * lane)) % modv;
                if (!u && nbytes < 4 && v >= modv / 2) v = v + (64'h1_0000_0000 - modv);
                rd  = v[31:0];
                lat = 2;
            end else begin
                for (int i = 0; i < 4; i++) b[i] = ref_mem[idx][8*i +: 8];
                for (int j = 0; j < nbytes; j++) b[lane + j] = wd[8*j +: 8];
                ref_mem[idx] = {b[3], b[2], b[1], b[0]};
                ww  = ref_mem[idx];
                nwr = 1;
                lat = (nbytes == 4) ? 2 : 3;
            end
        end
    endfunction

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic do_req(input bit w, input bit [1:0] sz, input bit u, input bit [31:0] a, input bit [31:0] wd);
        bit        e, rdy_busy, rsp_e;
        bit [31:0] rd, ww, rsp_d, wr_dat, wr_adr;
        int        lat, nwr, got_k, wr_cnt, idx;
        model(w, sz, u, a, wd, e, rd, lat, ww, nwr);
        idx = int'(a[6:2]);
        chk("ready_idle", 32'(REQ_READY), 32'd1);
        REQ_VALID = 1'b1; REQ_WRITE = w; REQ_SIZE = sz; REQ_UNSIGNED = u; REQ_ADDR = a; REQ_WDATA = wd;
        got_k = 0; wr_cnt = 0; rdy_busy = 0; rsp_e = 0; rsp_d = 0; wr_dat = 0; wr_adr = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            REQ_VALID = 1'b0;
            if (MEM_WRITE) begin wr_cnt++; wr_dat = MEM_WRITE_DATA; wr_adr = MEM_ADRESS; end
            if (REQ_READY) rdy_busy = 1;
            if (RSP_VALID) begin got_k = k; rsp_e = RSP_ERROR; rsp_d = RSP_RDATA; break; end
        end
        chk("rsp_latency", 32'(got_k), 32'(lat));
        chk("rsp_error", 32'(rsp_e), 32'(e));
        chk("rsp_rdata", rsp_d, rd);
        chk("mem_write_cycles", 32'(wr_cnt), 32'(nwr));
        chk("ready_low_busy", 32'(rdy_busy), 32'd0);
        if (nwr != 0) begin
            chk("mem_write_index", wr_adr, 32'(idx));
            chk("mem_write_data", wr_dat, ww);
        end
        @(negedge CLK);
        chk("rsp_one_cycle", 32'(RSP_VALID), 32'd0);
        if (!e) chk("mem_word", mem[idx], ref_mem[idx]);
        last_rd = rsp_d;
    endtask

    initial begin
        bit        e;
        bit [31:0] rd, ww, old_w, new_w, exp_a, exp_b;
        int        lat, nwr, nrsp, rsp_seen;
        int        rsp_k   [2];
        bit [31:0] rsp_dat [2];
        bit        rdy_k   [9];

        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = $urandom;
            mem[i]     = ref_mem[i];
        end

        // Reset state
        #2 RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_ready", 32'(REQ_READY), 32'd0);
        chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        chk("rst_mem_adress", MEM_ADRESS, 32'd0);
        chk("rst_mem_wdata", MEM_WRITE_DATA, 32'd0);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("rst_rsp_rdata", RSP_RDATA, 32'd0);
        chk("rst_rsp_error", 32'(RSP_ERROR), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Word store, then sub-word loads of it
        do_req(1'b1, S_W, 1'b0, 32'h10, 32'hDEADBEEF);
        chk("tp1_mem4", mem[4], 32'hDEADBEEF);
        do_req(1'b0, S_B, 1'b0, 32'h13, 32'h0);
        chk("tp2_lb", last_rd, 32'hFFFFFFDE);
        do_req(1'b0, S_B, 1'b1, 32'h13, 32'h0);
        chk("tp2_lbu", last_rd, 32'h000000DE);
        do_req(1'b0, S_H, 1'b0, 32'h10, 32'h0);
        chk("tp2_lh", last_rd, 32'hFFFFBEEF);

        // Half store RMW and readback
        do_req(1'b1, S_H, 1'b0, 32'h12, 32'h00001234);
        do_req(1'b0, S_W, 1'b0, 32'h10, 32'h0);
        chk("tp3_lw", last_rd, 32'h1234BEEF);

        // Rejected requests
        do_req(1'b0, S_W, 1'b0, 32'h11, 32'h0);
        do_req(1'b1, S_H, 1'b0, 32'h13, 32'hFFFF);
        do_req(1'b1, S_X, 1'b0, 32'h14, 32'h1);
        do_req(1'b0, S_B, 1'b0, 32'h80, 32'h0);

        // Two back-to-back loads with REQ_VALID held
        model(1'b0, S_W, 1'b0, 32'h10, 32'h0, e, exp_a, lat, ww, nwr);
        model(1'b0, S_W, 1'b0, 32'h14, 32'h0, e, exp_b, lat, ww, nwr);
        REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_SIZE = S_W; REQ_UNSIGNED = 1'b0; REQ_ADDR = 32'h10;
        nrsp = 0;
        rsp_k[0] = 0; rsp_k[1] = 0; rsp_dat[0] = 0; rsp_dat[1] = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (k == 1) REQ_ADDR = 32'h14;
            if (k == 4) REQ_VALID = 1'b0;
            rdy_k[k] = REQ_READY;
            if (RSP_VALID) begin
                if (nrsp < 2) begin rsp_k[nrsp] = k; rsp_dat[nrsp] = RSP_RDATA; end
                nrsp++;
            end
        end
        chk("hold_rsp_count", 32'(nrsp), 32'd2);
        chk("hold_rsp0_cycle", 32'(rsp_k[0]), 32'd2);
        chk("hold_rsp1_cycle", 32'(rsp_k[1]), 32'd5);
        chk("hold_rsp0_data", rsp_dat[0], exp_a);
        chk("hold_rsp1_data", rsp_dat[1], exp_b);
        chk("hold_ready_k1", 32'(rdy_k[1]), 32'd0);
        chk("hold_ready_k2", 32'(rdy_k[2]), 32'd0);
        chk("hold_ready_k3", 32'(rdy_k[3]), 32'd1);
        chk("hold_ready_k4", 32'(rdy_k[4]), 32'd0);
        chk("hold_ready_k5", 32'(rdy_k[5]), 32'd0);

        // Reset during the WRITE phase of a byte-store RMW
        old_w = ref_mem[6];
        model(1'b1, S_B, 1'b0, 32'h1A, 32'h000000A5, e, rd, lat, ww, nwr);
        new_w = ref_mem[6];
        REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_SIZE = S_B; REQ_ADDR = 32'h1A; REQ_WDATA = 32'h000000A5;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        chk("rmw_read_phase", 32'(MEM_WRITE), 32'd0);
        @(negedge CLK);
        chk("rmw_write_phase", 32'(MEM_WRITE), 32'd1);
        RST = 1'b1;
        #1;
        chk("abort_mem_write", 32'(MEM_WRITE), 32'd0);
        chk("abort_ready", 32'(REQ_READY), 32'd0);
        rsp_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (RSP_VALID) rsp_seen++;
        end
        chk("abort_no_rsp", 32'(rsp_seen), 32'd0);
        RST = 1'b0;
        #1;
        chk("post_rst_ready", 32'(REQ_READY), 32'd1);
        chk("post_rst_mem_adress", MEM_ADRESS, 32'd0);
        chk("post_rst_mem_wdata", MEM_WRITE_DATA, 32'd0);
        chk("post_rst_rsp_rdata", RSP_RDATA, 32'd0);
        chk("post_rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("no_torn_word", 32'((mem[6] === old_w) || (mem[6] === new_w)), 32'd1);
        ref_mem[6] = (mem[6] === new_w) ? new_w : old_w;
        @(negedge CLK);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            bit        w, u;
            bit [1:0]  sz;
            bit [31:0] a;
            w  = $urandom_range(0, 1) == 1;
            u  = $urandom_range(0, 1) == 1;
            sz = ($urandom_range(0, 7) == 0) ? S_X : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) begin
                if (sz == S_H) a[0] = 1'b0;
                if (sz == S_W) a[1:0] = 2'b00;
            end
            do_req(w, sz, u, a, $urandom);
        end

        for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
